// File: rtl/input_skew_pkg.sv
// Shared types and width helpers for the input skew buffer and its per-lane storage.
package input_skew_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ARRAY_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int step_width(input int k_max, input int array_w);
        return $clog2(k_max + array_w);
    endfunction

    function automatic int pace_width(input int interval);
        return (interval > 1) ? $clog2(interval) : 1;
    endfunction

    function automatic int idx_width(input int k_max);
        return (k_max > 1) ? $clog2(k_max) : 1;
    endfunction

endpackage

// File: rtl/input_skew_buffer_lane.sv
// One lane of the skew buffer: K_MAX-deep element store plus the read-side
// index/mask decode for this lane's diagonal offset.
module skew_lane
    import input_skew_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ARRAY_W = DEF_ARRAY_W,
    parameter int K_MAX   = 16,
    parameter int LANE    = 0
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [idx_width(K_MAX)-1:0]         waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [step_width(K_MAX,ARRAY_W)-1:0] step,
    input  logic [cnt_width(K_MAX)-1:0]         len,
    input  logic                                skew,
    input  logic                                show,
    output logic [DATA_W-1:0]                   data,
    output logic                                mask
);

    localparam int STEP_W = step_width(K_MAX, ARRAY_W);
    localparam int IDX_W  = idx_width(K_MAX);
    localparam logic [STEP_W:0] OFFSET = (STEP_W+1)'(LANE);

    logic [DATA_W-1:0] mem [0:K_MAX-1];
    logic [STEP_W:0]   diff;
    logic [STEP_W-1:0] k;
    logic              hit;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The extra top bit of diff is the borrow: step earlier than this lane's offset.
    always_comb begin
        diff = skew ? ({1'b0, step} - OFFSET) : {1'b0, step};
        k    = diff[STEP_W-1:0];
        hit  = !diff[STEP_W] && (k < STEP_W'(len));
    end

    assign mask = show && hit;
    assign data = (show && hit) ? mem[k[IDX_W-1:0]] : '0;

endmodule

// File: rtl/input_skew_buffer.sv
// Loads up to K_MAX operand vectors, then replays them with per-lane diagonal
// skew, programmable pacing and downstream backpressure.
module input_skew_buffer
    import input_skew_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ARRAY_W      = DEF_ARRAY_W,
    parameter int K_MAX        = 16,
    parameter int OUT_INTERVAL = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      skew_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ARRAY_W*DATA_W-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ARRAY_W*DATA_W-1:0] out_data,
    output logic [ARRAY_W-1:0]        out_mask,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output state_t                    fsm_state
);

    localparam int CNT_W  = cnt_width(K_MAX);
    localparam int STEP_W = step_width(K_MAX, ARRAY_W);
    localparam int PACE_W = pace_width(OUT_INTERVAL);
    localparam int IDX_W  = idx_width(K_MAX);
    localparam logic [PACE_W-1:0] PACE_INIT = PACE_W'(OUT_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(K_MAX - 1);
    localparam logic [STEP_W-1:0] SKEW_EXT  = STEP_W'(ARRAY_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  len;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] last_step;
    logic [PACE_W-1:0] pace;
    logic              skew;
    logic              we;

    assign last_step = STEP_W'(len) + (skew ? SKEW_EXT : '0) - STEP_W'(1);

    // Handshakes: a transfer happens in any cycle where valid && ready; the
    // producer holds valid and data stable until that cycle.
    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_DRAIN) && (pace == '0);
    assign out_last  = out_valid && (step == last_step);
    assign busy      = (state != ST_LOAD);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;
    assign we        = in_valid && (state == ST_LOAD) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_LOAD;
            wr_cnt <= '0;
            len    <= '0;
            step   <= '0;
            pace   <= '0;
            skew   <= 1'b0;
        end else if (clear) begin
            state  <= ST_LOAD;
            wr_cnt <= '0;
            len    <= '0;
            step   <= '0;
            pace   <= '0;
            skew   <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        // The K_MAX-th vector closes the load even without in_last.
                        if (in_last || wr_cnt == LAST_IDX) begin
                            state <= ST_DRAIN;
                            len   <= wr_cnt + 1'b1;
                            skew  <= skew_en;
                            pace  <= PACE_INIT;
                            step  <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pace != '0) begin
                        pace <= pace - 1'b1;
                    end else if (out_ready) begin
                        step <= step + 1'b1;
                        pace <= PACE_INIT;
                        if (step == last_step) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state  <= ST_LOAD;
                    wr_cnt <= '0;
                    step   <= '0;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    for (genvar c = 0; c < ARRAY_W; c++) begin : g_lane
        skew_lane #(
            .DATA_W (DATA_W),
            .ARRAY_W(ARRAY_W),
            .K_MAX  (K_MAX),
            .LANE   (c)
        ) u_lane (
            .clk  (clk),
            .we   (we),
            .waddr(wr_cnt[IDX_W-1:0]),
            .wdata(in_data[c*DATA_W +: DATA_W]),
            .step (step),
            .len  (len),
            .skew (skew),
            .show (out_valid),
            .data (out_data[c*DATA_W +: DATA_W]),
            .mask (out_mask[c])
        );
    end

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer: one instance at OUT_INTERVAL=1, one at 3.
module tb_input_skew_buffer;
    import input_skew_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int KM = 16;
    localparam int W  = DW * AW;
    localparam int EW = W + AW + 1;

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] mask;
        logic          last;
    } step_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    clear, skew_en, in_valid, in_last, out_ready;
    logic [W-1:0]  in_data  [2];
    logic [1:0]    in_ready, out_valid, out_last, busy, done;
    logic [W-1:0]  out_data [2];
    logic [AW-1:0] out_mask [2];
    state_t        fsm_state[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        input_skew_buffer #(
            .DATA_W(DW), .ARRAY_W(AW), .K_MAX(KM), .OUT_INTERVAL(g == 0 ? 1 : 3)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .clear(clear[g]), .skew_en(skew_en[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .in_last(in_last[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_data(out_data[g]), .out_mask(out_mask[g]), .out_last(out_last[g]),
            .busy(busy[g]), .done(done[g]), .fsm_state(fsm_state[g])
        );
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    step_t tab[13];

    function automatic logic [W-1:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int sel, input logic [W-1:0] vecs[$], input bit use_last);
        foreach (vecs[i]) begin
            chk("in_ready_load", W'(in_ready[sel]), W'(1));
            in_valid[sel] = 1'b1;
            in_data[sel]  = vecs[i];
            in_last[sel]  = use_last && (i == vecs.size() - 1);
            tick();
        end
        in_valid[sel] = 1'b0;
        in_last[sel]  = 1'b0;
    endtask

    task automatic push_tab(input int first, input int n);
        for (int i = first; i < first + n; i++)
            exp_q.push_back({tab[i].last, tab[i].mask, tab[i].data});
    endtask

    task automatic wait_valid(input int sel, output int waited);
        waited = 0;
        while (!out_valid[sel] && waited < 40) begin
            tick();
            waited++;
        end
        chk("valid_timeout", W'(out_valid[sel]), W'(1));
    endtask

    task automatic drain_n(input int sel, input int n, input bit gapless);
        int waited;
        logic [EW-1:0] e;
        for (int i = 0; i < n; i++) begin
            wait_valid(sel, waited);
            if (gapless) chk("step_gap", W'(waited), W'(0));
            if (exp_q.size() == 0) begin
                chk("exp_underflow", W'(1), W'(0));
            end else begin
                e = exp_q.pop_front();
                chk("step_data", out_data[sel], e[W-1:0]);
                chk("step_mask", W'(out_mask[sel]), W'(e[W+AW-1:W]));
                chk("step_last", W'(out_last[sel]), W'(e[EW-1]));
            end
            out_ready[sel] = 1'b1;
            tick();
            out_ready[sel] = 1'b0;
        end
    endtask

    task automatic finish_chk(input int sel);
        chk("done_pulse", W'(done[sel]), W'(1));
        chk("busy_in_done", W'(busy[sel]), W'(1));
        chk("in_ready_in_done", W'(in_ready[sel]), W'(0));
        chk("state_done", W'(fsm_state[sel]), W'(ST_DONE));
        tick();
        chk("done_drop", W'(done[sel]), W'(0));
        chk("in_ready_idle", W'(in_ready[sel]), W'(1));
        chk("busy_idle", W'(busy[sel]), W'(0));
    endtask

    task automatic idle_chk(input int sel, input string tag);
        chk({tag, "_in_ready"}, W'(in_ready[sel]), W'(1));
        chk({tag, "_out_valid"}, W'(out_valid[sel]), W'(0));
        chk({tag, "_out_data"}, out_data[sel], W'(0));
        chk({tag, "_out_mask"}, W'(out_mask[sel]), W'(0));
        chk({tag, "_out_last"}, W'(out_last[sel]), W'(0));
        chk({tag, "_busy"}, W'(busy[sel]), W'(0));
        chk({tag, "_done"}, W'(done[sel]), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] v3[$];
        logic [W-1:0] v16[$];
        logic [W-1:0] v1[$];
        logic [W-1:0] d;
        logic [AW-1:0] m;
        int waited;

        tab[0]  = '{pk(1, 0, 0, 0),   4'b0001, 1'b0};
        tab[1]  = '{pk(5, 2, 0, 0),   4'b0011, 1'b0};
        tab[2]  = '{pk(9, 6, 3, 0),   4'b0111, 1'b0};
        tab[3]  = '{pk(0, 10, 7, 4),  4'b1110, 1'b0};
        tab[4]  = '{pk(0, 0, 11, 8),  4'b1100, 1'b0};
        tab[5]  = '{pk(0, 0, 0, 12),  4'b1000, 1'b1};
        tab[6]  = '{pk(1, 2, 3, 4),   4'b1111, 1'b0};
        tab[7]  = '{pk(5, 6, 7, 8),   4'b1111, 1'b0};
        tab[8]  = '{pk(9, 10, 11, 12), 4'b1111, 1'b1};
        tab[9]  = '{pk(7, 0, 0, 0),   4'b0001, 1'b0};
        tab[10] = '{pk(0, 7, 0, 0),   4'b0010, 1'b0};
        tab[11] = '{pk(0, 0, 7, 0),   4'b0100, 1'b0};
        tab[12] = '{pk(0, 0, 0, 7),   4'b1000, 1'b1};

        v3 = '{pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(9, 10, 11, 12)};
        v1 = '{pk(7, 7, 7, 7)};
        for (int k = 0; k < KM; k++) v16.push_back(pk(4*k+1, 4*k+2, 4*k+3, 4*k+4));

        clear = '0; skew_en = '0; in_valid = '0; in_last = '0; out_ready = '0;
        in_data[0] = '0; in_data[1] = '0;

        // Reset state
        repeat (2) tick();
        idle_chk(0, "reset0");
        idle_chk(1, "reset1");
        rst_n = 1'b1;
        tick();

        // Basic skew, OUT_INTERVAL=1
        skew_en[0] = 1'b1;
        load(0, v3, 1'b1);
        push_tab(0, 6);
        drain_n(0, 6, 1'b1);
        finish_chk(0);

        // Skew bypass
        skew_en[0] = 1'b0;
        load(0, v3, 1'b1);
        push_tab(6, 3);
        drain_n(0, 3, 1'b1);
        finish_chk(0);

        // Pacing (OUT_INTERVAL=3) with a 4-cycle stall on step 2
        skew_en[1] = 1'b1;
        load(1, v3, 1'b1);
        for (int s = 0; s < 6; s++) begin
            repeat (2) begin
                chk("pace_gap", W'(out_valid[1]), W'(0));
                tick();
            end
            chk("pace_valid", W'(out_valid[1]), W'(1));
            chk("pace_data", out_data[1], tab[s].data);
            chk("pace_mask", W'(out_mask[1]), W'(tab[s].mask));
            chk("pace_last", W'(out_last[1]), W'(tab[s].last));
            if (s == 2) begin
                repeat (4) begin
                    tick();
                    chk("stall_valid", W'(out_valid[1]), W'(1));
                    chk("stall_data", out_data[1], tab[2].data);
                    chk("stall_mask", W'(out_mask[1]), W'(tab[2].mask));
                end
            end
            out_ready[1] = 1'b1;
            tick();
            out_ready[1] = 1'b0;
        end
        finish_chk(1);

        // Capacity: 16 vectors, no in_last; model the 19 skewed steps
        skew_en[0] = 1'b1;
        load(0, v16, 1'b0);
        chk("in_ready_full", W'(in_ready[0]), W'(0));
        for (int s = 0; s < KM + AW - 1; s++) begin
            d = '0;
            m = '0;
            for (int c = 0; c < AW; c++) begin
                if (s - c >= 0 && s - c < KM) begin
                    d[c*DW +: DW] = 8'(4*(s-c) + c + 1);
                    m[c] = 1'b1;
                end
            end
            exp_q.push_back({(s == KM + AW - 2), m, d});
        end
        drain_n(0, KM + AW - 1, 1'b1);
        finish_chk(0);

        // Clear at step 2, with a vector presented in the same cycle
        load(0, v3, 1'b1);
        push_tab(0, 6);
        drain_n(0, 2, 1'b1);
        wait_valid(0, waited);
        chk("pre_clear_data", out_data[0], tab[2].data);
        clear[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = pk(85, 85, 85, 85);
        tick();
        clear[0] = 1'b0;
        in_valid[0] = 1'b0;
        idle_chk(0, "after_clear");
        exp_q.delete();

        // in_valid held through DRAIN and DONE is ignored
        skew_en[0] = 1'b0;
        load(0, v3, 1'b1);
        in_valid[0] = 1'b1;
        in_last[0] = 1'b1;
        in_data[0] = pk(170, 170, 170, 170);
        push_tab(6, 3);
        drain_n(0, 3, 1'b1);
        finish_chk(0);
        in_valid[0] = 1'b0;
        in_last[0] = 1'b0;

        // Single-vector load starts at index 0
        skew_en[0] = 1'b1;
        load(0, v1, 1'b1);
        push_tab(9, 4);
        drain_n(0, 4, 1'b1);
        finish_chk(0);

        // Async reset mid-drain
        load(0, v3, 1'b1);
        push_tab(0, 6);
        drain_n(0, 2, 1'b1);
        wait_valid(0, waited);
        chk("pre_reset_mask", W'(out_mask[0]), W'(tab[2].mask));
        #1 rst_n = 1'b0;
        #1;
        idle_chk(0, "async_reset");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        idle_chk(0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
